// File: rtl/mor1kx_store_buffer_drain.sv
// Store buffer drain: pops queued stores onto the data bus one at a time,
// handling store-conditional drops, bus errors and sync requests.
module mor1kx_store_buffer_drain #(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sb_empty_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
  input  logic                              sb_atomic_i,
  output logic                              sb_read_o,
  input  logic                              atomic_ok_i,
  output logic                              atomic_fail_o,
  output logic                              dbus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
  input  logic                              dbus_ack_i,
  input  logic                              dbus_err_i,
  output logic                              bus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
  input  logic                              err_clr_i,
  input  logic                              sync_req_i,
  output logic                              sync_done_o,
  output logic                              busy_o
);

  localparam int W = OPTION_OPERAND_WIDTH;
  localparam int B = OPTION_OPERAND_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    ERR
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   pc_q;
  logic           drop;
  logic           ack_ok;

  assign drop   = sb_atomic_i & ~atomic_ok_i;
  assign ack_ok = dbus_ack_i & ~dbus_err_i;
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    sb_read_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!sb_empty_i) begin
          sb_read_o = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        state_d = drop ? IDLE : WRITE;
      end
      WRITE: begin
        if (dbus_err_i) begin
          state_d = ERR;
        end else if (ack_ok) begin
          // Pop the next entry in the ack cycle to avoid an idle bubble
          if (!sb_empty_i) begin
            sb_read_o = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ERR: begin
        if (err_clr_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      dbus_req_o    <= 1'b0;
      dbus_adr_o    <= '0;
      dbus_dat_o    <= '0;
      dbus_bsel_o   <= '0;
      pc_q          <= '0;
      err_pc_o      <= '0;
      bus_err_o     <= 1'b0;
      atomic_fail_o <= 1'b0;
      sync_done_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      atomic_fail_o <= (state_q == FETCH) && drop;
      sync_done_o   <= sync_req_i && sb_empty_i &&
                       (state_q == IDLE);
      if (state_q == FETCH) begin
        dbus_adr_o  <= sb_adr_i;
        dbus_dat_o  <= sb_dat_i;
        dbus_bsel_o <= sb_bsel_i[B-1:0];
        pc_q        <= sb_pc_i;
        dbus_req_o  <= !drop;
      end
      if (state_q == WRITE) begin
        if (dbus_err_i || dbus_ack_i) dbus_req_o <= 1'b0;
        if (dbus_err_i) begin
          err_pc_o  <= pc_q;
          bus_err_o <= 1'b1;
        end
      end
      if (state_q == ERR && err_clr_i) bus_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mor1kx_store_buffer_drain.sv
// Directed bench for the store buffer drain: FIFO and bus responder models,
// a vector table for single stores, and sequences for multi-cycle cases.
module tb_mor1kx_store_buffer_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sb_empty_i;
  logic [31:0] sb_adr_i = '0;
  logic [31:0] sb_dat_i = '0;
  logic [3:0]  sb_bsel_i = '0;
  logic [31:0] sb_pc_i = '0;
  logic        sb_atomic_i = 1'b0;
  logic        sb_read_o;
  logic        atomic_ok_i = 1'b1;
  logic        atomic_fail_o;
  logic        dbus_req_o;
  logic [31:0] dbus_adr_o;
  logic [31:0] dbus_dat_o;
  logic [3:0]  dbus_bsel_o;
  logic        dbus_ack_i = 1'b0;
  logic        dbus_err_i = 1'b0;
  logic        bus_err_o;
  logic [31:0] err_pc_o;
  logic        err_clr_i = 1'b0;
  logic        sync_req_i = 1'b0;
  logic        sync_done_o;
  logic        busy_o;

  mor1kx_store_buffer_drain #(.OPTION_OPERAND_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .sb_empty_i(sb_empty_i), .sb_adr_i(sb_adr_i),
    .sb_dat_i(sb_dat_i), .sb_bsel_i(sb_bsel_i),
    .sb_pc_i(sb_pc_i), .sb_atomic_i(sb_atomic_i),
    .sb_read_o(sb_read_o), .atomic_ok_i(atomic_ok_i),
    .atomic_fail_o(atomic_fail_o), .dbus_req_o(dbus_req_o),
    .dbus_adr_o(dbus_adr_o), .dbus_dat_o(dbus_dat_o),
    .dbus_bsel_o(dbus_bsel_o), .dbus_ack_i(dbus_ack_i),
    .dbus_err_i(dbus_err_i), .bus_err_o(bus_err_o),
    .err_pc_o(err_pc_o), .err_clr_i(err_clr_i),
    .sync_req_i(sync_req_i), .sync_done_o(sync_done_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Store buffer model: head appears on sb_* the cycle after a pop
  logic [31:0] f_adr [16];
  logic [31:0] f_dat [16];
  logic [3:0]  f_bsel [16];
  logic [31:0] f_pc [16];
  logic        f_at [16];
  logic [3:0]  wp = '0;
  logic [3:0]  rp = '0;
  assign sb_empty_i = (wp == rp);

  always @(posedge clk) begin
    if (sb_read_o) begin
      sb_adr_i    <= f_adr[rp];
      sb_dat_i    <= f_dat[rp];
      sb_bsel_i   <= f_bsel[rp];
      sb_pc_i     <= f_pc[rp];
      sb_atomic_i <= f_at[rp];
      rp          <= rp + 4'd1;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] p,
                      input logic at);
    f_adr[wp]  = a;
    f_dat[wp]  = d;
    f_bsel[wp] = b;
    f_pc[wp]   = p;
    f_at[wp]   = at;
    wp         = wp + 4'd1;
  endtask

  // Bus responder: ack (or err on err_adr) ack_lat cycles after req
  int          ack_lat = 0;
  int          rcnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_adr = '0;

  always @(negedge clk) begin
    dbus_ack_i = 1'b0;
    dbus_err_i = 1'b0;
    if (dbus_req_o && !rst) begin
      if (rcnt >= ack_lat) begin
        if (err_en && dbus_adr_o == err_adr) dbus_err_i = 1'b1;
        else dbus_ack_i = 1'b1;
        rcnt = 0;
      end else begin
        rcnt++;
      end
    end else begin
      rcnt = 0;
    end
  end

  // Monitors
  logic [31:0] wl_adr [64];
  logic [31:0] wl_dat [64];
  logic [3:0]  wl_bsel [64];
  int          nwrites = 0;
  int          nreads = 0;
  int          nfails = 0;
  int          v_empty_rd = 0;
  int          v_err_rd = 0;
  int          v_b2b = 0;
  int          v_stab = 0;
  int          v_pulse = 0;
  int          v_sync_err = 0;
  logic        prev_req = 1'b0;
  logic        prev_fail = 1'b0;
  logic [31:0] prev_adr = '0;
  logic [31:0] prev_dat = '0;

  always @(posedge clk) begin
    if (!rst) begin
      if (sb_read_o) nreads++;
      if (sb_read_o && sb_empty_i) v_empty_rd++;
      if (sb_read_o && bus_err_o) v_err_rd++;
      if (dbus_req_o && dbus_ack_i && !dbus_err_i) begin
        wl_adr[nwrites]  = dbus_adr_o;
        wl_dat[nwrites]  = dbus_dat_o;
        wl_bsel[nwrites] = dbus_bsel_o;
        nwrites++;
        if (!sb_empty_i && !sb_read_o) v_b2b++;
      end
    end
  end

  always @(negedge clk) begin
    if (atomic_fail_o) nfails++;
    if (atomic_fail_o && prev_fail) v_pulse++;
    if (bus_err_o && sync_done_o) v_sync_err++;
    if (dbus_req_o && prev_req &&
        (dbus_adr_o != prev_adr || dbus_dat_o != prev_dat))
      v_stab++;
    prev_fail = atomic_fail_o;
    prev_req  = dbus_req_o;
    prev_adr  = dbus_adr_o;
    prev_dat  = dbus_dat_o;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy_o && sb_empty_i && !dbus_req_o) break;
    end
    check({nm, "_timeout"}, 64'(k >= 100), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
    logic [31:0] pc;
    logic        atomic;
    logic        ok;
    int          lat;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int w0, r0, f0, lat_seen, cyc, k;

    vecs[0] = '{32'h100, 32'hDEADBEEF, 4'hF, 32'h2000, 1'b0, 1'b1, 2, 1'b1};
    vecs[1] = '{32'h110, 32'h11112222, 4'hF, 32'h2004, 1'b1, 1'b0, 0, 1'b0};
    vecs[2] = '{32'h120, 32'h33334444, 4'hC, 32'h2008, 1'b1, 1'b1, 1, 1'b1};
    vecs[3] = '{32'h130, 32'h55556666, 4'h3, 32'h200C, 1'b0, 1'b0, 0, 1'b1};
    vecs[4] = '{32'h140, 32'h77778888, 4'h1, 32'h2010, 1'b1, 1'b0, 3, 1'b0};

    // Reset state
    #12;
    check("rst_sb_read", 64'(sb_read_o), 64'd0);
    check("rst_req", 64'(dbus_req_o), 64'd0);
    check("rst_fail", 64'(atomic_fail_o), 64'd0);
    check("rst_bus_err", 64'(bus_err_o), 64'd0);
    check("rst_sync", 64'(sync_done_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_adr", 64'(dbus_adr_o), 64'd0);
    check("rst_err_pc", 64'(err_pc_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single-store vectors
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ack_lat     = vecs[i].lat;
      atomic_ok_i = vecs[i].ok;
      w0 = nwrites;
      r0 = nreads;
      f0 = nfails;
      push(vecs[i].adr, vecs[i].dat, vecs[i].bsel, vecs[i].pc,
           vecs[i].atomic);
      lat_seen = -1;
      cyc = 0;
      for (k = 0; k < 60; k++) begin
        @(negedge clk);
        cyc++;
        if (dbus_req_o && lat_seen < 0) lat_seen = cyc;
        if (cyc > 2 && !busy_o && sb_empty_i && !dbus_req_o) break;
      end
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_timeout", i), 64'(k >= 60), 64'd0);
      check($sformatf("v%0d_reads", i), 64'(nreads - r0), 64'd1);
      check($sformatf("v%0d_writes", i), 64'(nwrites - w0),
            64'(vecs[i].exp_wr));
      check($sformatf("v%0d_fail_pulse", i), 64'(nfails - f0),
            64'(!vecs[i].exp_wr));
      check($sformatf("v%0d_req_latency", i), 64'(lat_seen),
            vecs[i].exp_wr ? 64'd2 : 64'hFFFF_FFFF_FFFF_FFFF);
      if (vecs[i].exp_wr && nwrites > w0) begin
        check($sformatf("v%0d_adr", i), 64'(wl_adr[w0]),
              64'(vecs[i].adr));
        check($sformatf("v%0d_dat", i), 64'(wl_dat[w0]),
              64'(vecs[i].dat));
        check($sformatf("v%0d_bsel", i), 64'(wl_bsel[w0]),
              64'(vecs[i].bsel));
      end
    end
    atomic_ok_i = 1'b1;

    // Back-to-back with same-cycle ack
    @(negedge clk);
    ack_lat = 0;
    w0 = nwrites;
    push(32'h200, 32'hA0, 4'hF, 32'h2100, 1'b0);
    push(32'h204, 32'hA1, 4'hF, 32'h2104, 1'b0);
    push(32'h208, 32'hA2, 4'hF, 32'h2108, 1'b0);
    cyc = 0;
    for (k = 0; k < 60 && nwrites < w0 + 3; k++) begin
      @(negedge clk);
      if (nwrites > w0 && nwrites < w0 + 3 && !busy_o) cyc++;
    end
    check("b2b_timeout", 64'(k >= 60), 64'd0);
    check("b2b_idle_gap", 64'(cyc), 64'd0);
    check("b2b_adr0", 64'(wl_adr[w0]), 64'h200);
    check("b2b_adr1", 64'(wl_adr[w0 + 1]), 64'h204);
    check("b2b_adr2", 64'(wl_adr[w0 + 2]), 64'h208);
    check("b2b_dat2", 64'(wl_dat[w0 + 2]), 64'hA2);
    check("b2b_pop_in_ack", 64'(v_b2b), 64'd0);
    wait_idle("b2b");

    // Bus error with two entries behind it
    @(negedge clk);
    ack_lat = 1;
    err_en = 1'b1;
    err_adr = 32'h404;
    sync_req_i = 1'b1;
    w0 = nwrites;
    push(32'h404, 32'hE0, 4'hF, 32'h3004, 1'b0);
    push(32'h408, 32'hE1, 4'hF, 32'h3008, 1'b0);
    push(32'h40C, 32'hE2, 4'hF, 32'h300C, 1'b0);
    for (k = 0; k < 40 && !bus_err_o; k++) @(negedge clk);
    check("err_timeout", 64'(k >= 40), 64'd0);
    check("err_flag", 64'(bus_err_o), 64'd1);
    check("err_pc", 64'(err_pc_o), 64'h3004);
    r0 = nreads;
    repeat (10) @(negedge clk);
    check("err_no_pops", 64'(nreads - r0), 64'd0);
    check("err_req_low", 64'(dbus_req_o), 64'd0);
    check("err_sticky", 64'(bus_err_o), 64'd1);
    check("err_no_write", 64'(nwrites - w0), 64'd0);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    check("err_cleared", 64'(bus_err_o), 64'd0);
    err_en = 1'b0;
    wait_idle("err_drain");
    check("err_drain_cnt", 64'(nwrites - w0), 64'd2);
    check("err_drain_adr0", 64'(wl_adr[w0]), 64'h408);
    check("err_drain_adr1", 64'(wl_adr[w0 + 1]), 64'h40C);
    check("err_sync_low", 64'(v_sync_err), 64'd0);
    sync_req_i = 1'b0;
    repeat (2) @(negedge clk);

    // Sync with two queued stores
    ack_lat = 1;
    w0 = nwrites;
    push(32'h500, 32'hC0, 4'hF, 32'h4000, 1'b0);
    push(32'h504, 32'hC1, 4'hF, 32'h4004, 1'b0);
    sync_req_i = 1'b1;
    cyc = 0;
    for (k = 0; k < 60 && nwrites < w0 + 2; k++) begin
      @(negedge clk);
      if (sync_done_o) cyc++;
    end
    check("sync_timeout", 64'(k >= 60), 64'd0);
    check("sync_early", 64'(cyc), 64'd0);
    @(negedge clk);
    check("sync_rise", 64'(sync_done_o), 64'd1);
    sync_req_i = 1'b0;
    @(negedge clk);
    check("sync_fall", 64'(sync_done_o), 64'd0);

    // Async reset in the middle of a write
    ack_lat = 20;
    push(32'h600, 32'hF0, 4'hF, 32'h5000, 1'b0);
    for (k = 0; k < 20 && !dbus_req_o; k++) @(negedge clk);
    check("arst_req_seen", 64'(dbus_req_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", 64'(dbus_req_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = nreads;
    repeat (5) @(negedge clk);
    check("arst_no_pop", 64'(nreads - r0), 64'd0);
    check("arst_idle", 64'(busy_o), 64'd0);

    check("no_pop_empty", 64'(v_empty_rd), 64'd0);
    check("no_pop_err", 64'(v_err_rd), 64'd0);
    check("req_stable", 64'(v_stab), 64'd0);
    check("fail_one_cycle", 64'(v_pulse), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
